// File: rtl/se_test_pkg.sv
// Shared types and helpers for the self-composition test harness monitors.
package se_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1024;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_value;
        max_value = (32'd1 << width) - 32'd1;
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/se_lane_capture.sv
// Per-lane capture: remembers the first valid of a transaction, its latency and its result.
module se_lane_capture #(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              sample,
    input  logic              valid,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [DATA_W-1:0] lane_result,
    output logic              done,
    output logic [CNT_W-1:0]  latency,
    output logic [DATA_W-1:0] captured
);

    logic capture;

    // A lane holds valid until it is drained, so only its first valid counts.
    assign capture = sample & valid & ~done;

    always_ff @(posedge clock) begin
        if (reset) begin
            done    <= 1'b0;
            latency <= '0;
        end else if (start) begin
            done <= 1'b0;
        end else if (capture) begin
            done    <= 1'b1;
            latency <= cnt;
        end
    end

    // NOTE: the wide result register carries no reset; it is only read after
    // every lane's done bit has been set by a fresh capture.
    always_ff @(posedge clock) begin
        if (capture) begin
            captured <= lane_result;
        end
    end

endmodule

// File: rtl/se_leak_monitor.sv
// N-lane timing-leak and result-equivalence monitor: per-transaction latency
// accounting, skew/divergence detection, sticky flags and saturating counters.
module se_leak_monitor
    import se_test_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 128,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_in_fire,
    input  logic [NUM_LANES-1:0]          io_lane_valid,
    input  logic [NUM_LANES*DATA_W-1:0]   io_lane_result,
    input  logic                          io_clear,
    output logic                          io_busy,
    output logic                          io_done,
    output logic [CNT_W-1:0]              io_latency,
    output logic [CNT_W-1:0]              io_skew,
    output logic                          io_leak,
    output logic                          io_mismatch,
    output logic                          io_timeout,
    output logic                          io_proto_err,
    output logic [CNT_W-1:0]              io_txn_count,
    output logic [CNT_W-1:0]              io_leak_count
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_LANES-1:0] lane_done;
    logic [CNT_W-1:0]   lane_lat  [NUM_LANES];
    logic [DATA_W-1:0]  lane_data [NUM_LANES];

    logic start, sample, all_done;
    logic [CNT_W-1:0] lat_max, lat_min, skew;
    logic diverged;
    logic done_evt, timeout_evt, skew_evt, proto_evt;
    logic [CNT_W-1:0] txn_base, leak_cnt_base;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] value);
        return CNT_W'(sat_inc(32'(value), CNT_W));
    endfunction

    assign start  = (state == IDLE) & io_in_fire;
    assign sample = (state == WAIT);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        se_lane_capture #(
            .CNT_W  (CNT_W),
            .DATA_W (DATA_W)
        ) u_capture (
            .clock       (clock),
            .reset       (reset),
            .start       (start),
            .sample      (sample),
            .valid       (io_lane_valid[i]),
            .cnt         (cnt),
            .lane_result (io_lane_result[i*DATA_W +: DATA_W]),
            .done        (lane_done[i]),
            .latency     (lane_lat[i]),
            .captured    (lane_data[i])
        );
    end

    // Lanes capturing this cycle count as done for the exit decision.
    assign all_done = &(lane_done | io_lane_valid);

    always_comb begin
        // NOTE: defaults first, so no path through the loop leaves a latch.
        lat_max  = lane_lat[0];
        lat_min  = lane_lat[0];
        diverged = 1'b0;
        for (int i = 1; i < NUM_LANES; i++) begin
            if (lane_lat[i] > lat_max) lat_max = lane_lat[i];
            if (lane_lat[i] < lat_min) lat_min = lane_lat[i];
            if (lane_data[i] != lane_data[0]) diverged = 1'b1;
        end
    end

    assign skew        = lat_max - lat_min;
    assign done_evt    = (state == DONE);
    assign timeout_evt = (state == WAIT) & ~all_done & (cnt == CNT_W'(TIMEOUT));
    assign skew_evt    = done_evt & (skew != '0);
    assign proto_evt   = io_in_fire & (state != IDLE);

    assign txn_base      = io_clear ? '0 : io_txn_count;
    assign leak_cnt_base = io_clear ? '0 : io_leak_count;
    assign io_busy       = (state != IDLE);

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            io_done       <= 1'b0;
            io_latency    <= '0;
            io_skew       <= '0;
            io_leak       <= 1'b0;
            io_mismatch   <= 1'b0;
            io_timeout    <= 1'b0;
            io_proto_err  <= 1'b0;
            io_txn_count  <= '0;
            io_leak_count <= '0;
        end else begin
            io_done <= done_evt;
            case (state)
                IDLE: begin
                    if (io_in_fire) begin
                        cnt   <= CNT_W'(1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (all_done) begin
                        state <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    io_latency <= lane_lat[0];
                    io_skew    <= skew;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A set or increment in the same cycle as a clear takes effect.
            io_leak       <= (io_leak & ~io_clear) | timeout_evt | skew_evt;
            io_mismatch   <= (io_mismatch & ~io_clear) | (done_evt & diverged);
            io_timeout    <= (io_timeout & ~io_clear) | timeout_evt;
            io_proto_err  <= (io_proto_err & ~io_clear) | proto_evt;
            io_txn_count  <= done_evt ? bump(txn_base) : txn_base;
            io_leak_count <= (timeout_evt | skew_evt) ? bump(leak_cnt_base) : leak_cnt_base;
        end
    end

endmodule

// File: tb/tb_se_leak_monitor.sv
// Randomized bench for se_leak_monitor: a 2-lane and a 4-lane instance share
// one transaction stream and are compared every cycle against an event model.
module tb_se_leak_monitor;

    localparam int DW   = 16;
    localparam int CW   = 5;
    localparam int TO   = 16;
    localparam int CMAX = (1 << CW) - 1;

    typedef int arr4_t[4];
    typedef logic [DW-1:0] res4_t[4];

    logic clock = 1'b0;
    logic reset, fire, clear;
    logic [3:0] valid;
    logic [DW-1:0] res_bus [4];
    logic [2*DW-1:0] bus2;
    logic [4*DW-1:0] bus4;

    logic busy2, done2, leak2, mis2, to2, pe2;
    logic [CW-1:0] lat2, skew2, txn2, lc2;
    logic busy4, done4, leak4, mis4, to4, pe4;
    logic [CW-1:0] lat4, skew4, txn4, lc4;

    int checks = 0;
    int errors = 0;

    // Model of each instance's visible outputs (index 0: 2 lanes, 1: 4 lanes).
    int m_busy[2], m_done[2], m_lat[2], m_skew[2];
    int m_leak[2], m_mis[2], m_to[2], m_pe[2], m_txn[2], m_lc[2];

    always #5 clock = ~clock;

    assign bus2 = {res_bus[1], res_bus[0]};
    assign bus4 = {res_bus[3], res_bus[2], res_bus[1], res_bus[0]};

    se_leak_monitor #(.NUM_LANES(2), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut2 (
        .clock(clock), .reset(reset), .io_in_fire(fire), .io_lane_valid(valid[1:0]),
        .io_lane_result(bus2), .io_clear(clear), .io_busy(busy2), .io_done(done2),
        .io_latency(lat2), .io_skew(skew2), .io_leak(leak2), .io_mismatch(mis2),
        .io_timeout(to2), .io_proto_err(pe2), .io_txn_count(txn2), .io_leak_count(lc2)
    );

    se_leak_monitor #(.NUM_LANES(4), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut4 (
        .clock(clock), .reset(reset), .io_in_fire(fire), .io_lane_valid(valid),
        .io_lane_result(bus4), .io_clear(clear), .io_busy(busy4), .io_done(done4),
        .io_latency(lat4), .io_skew(skew4), .io_leak(leak4), .io_mismatch(mis4),
        .io_timeout(to4), .io_proto_err(pe4), .io_txn_count(txn4), .io_leak_count(lc4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic int lanes(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic bit txn_complete(input arr4_t l, input int n);
        for (int i = 0; i < n; i++)
            if (l[i] < 1 || l[i] > TO) return 1'b0;
        return 1'b1;
    endfunction

    // Cycle (relative to the fire) at which the instance is back in IDLE.
    function automatic int txn_end(input arr4_t l, input int n);
        int mx = 0;
        if (!txn_complete(l, n)) return TO + 1;
        for (int i = 0; i < n; i++) if (l[i] > mx) mx = l[i];
        return mx + 2;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_done[d] = 0; m_lat[d] = 0; m_skew[d] = 0; m_leak[d] = 0;
            m_mis[d] = 0; m_to[d] = 0; m_pe[d] = 0; m_txn[d] = 0; m_lc[d] = 0;
        end
    endtask

    task automatic check_dut(input int d, input logic busy, input logic done,
                             input logic [CW-1:0] lat, input logic [CW-1:0] skew,
                             input logic leak, input logic mis, input logic to, input logic pe,
                             input logic [CW-1:0] txn, input logic [CW-1:0] lc);
        string p;
        p = $sformatf("n%0d", lanes(d));
        check({p, ".busy"},       64'(busy), 64'(m_busy[d]));
        check({p, ".done"},       64'(done), 64'(m_done[d]));
        check({p, ".latency"},    64'(lat),  64'(m_lat[d]));
        check({p, ".skew"},       64'(skew), 64'(m_skew[d]));
        check({p, ".leak"},       64'(leak), 64'(m_leak[d]));
        check({p, ".mismatch"},   64'(mis),  64'(m_mis[d]));
        check({p, ".timeout"},    64'(to),   64'(m_to[d]));
        check({p, ".proto_err"},  64'(pe),   64'(m_pe[d]));
        check({p, ".txn_count"},  64'(txn),  64'(m_txn[d]));
        check({p, ".leak_count"}, 64'(lc),   64'(m_lc[d]));
    endtask

    task automatic check_all();
        @(negedge clock);
        check_dut(0, busy2, done2, lat2, skew2, leak2, mis2, to2, pe2, txn2, lc2);
        check_dut(1, busy4, done4, lat4, skew4, leak4, mis4, to4, pe4, txn4, lc4);
    endtask

    // Idle cycles with junk lane valids, dropped in the last cycle before a fire.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            reset = 1'b0; fire = 1'b0; clear = 1'b0;
            valid = (k == n - 1) ? 4'h0 : 4'($urandom);
            for (int i = 0; i < 4; i++) res_bus[i] = DW'($urandom);
            m_busy[0] = 0; m_busy[1] = 0;
            check_all();
            @(posedge clock);
            m_done[0] = 0; m_done[1] = 0;
            #1;
        end
    endtask

    // One transaction: lane i first valid k=l[i] cycles after the fire (0: never),
    // held h[i] extra cycles with a different result after the first.
    task automatic run_txn(input arr4_t l, input res4_t r, input arr4_t h,
                           input int proto_c, input int clear_c, input int reset_c);
        int  ends[2];
        bit  comp[2];
        int  last = 0;
        for (int d = 0; d < 2; d++) begin
            comp[d] = txn_complete(l, lanes(d));
            ends[d] = txn_end(l, lanes(d));
            if (ends[d] > last) last = ends[d];
        end
        for (int c = 0; c < last; c++) begin
            reset = (c == reset_c);
            fire  = (c == 0) || (c == proto_c);
            clear = (c == clear_c);
            for (int i = 0; i < 4; i++) begin
                valid[i]   = (l[i] != 0) && (c >= l[i]) && (c <= l[i] + h[i]);
                res_bus[i] = (c == l[i]) ? r[i] : DW'($urandom);
            end
            for (int d = 0; d < 2; d++) m_busy[d] = (c >= 1 && c <= ends[d] - 1) ? 1 : 0;
            check_all();
            @(posedge clock);
            if (c == reset_c) begin
                model_reset();
                #1;
                reset = 1'b0;
                return;
            end
            for (int d = 0; d < 2; d++) begin
                int n = lanes(d);
                m_done[d] = 0;
                if (clear) begin
                    m_leak[d] = 0; m_mis[d] = 0; m_to[d] = 0; m_pe[d] = 0; m_txn[d] = 0; m_lc[d] = 0;
                end
                if (fire && c >= 1 && c <= ends[d] - 1) m_pe[d] = 1;
                if (c == ends[d] - 1) begin
                    if (comp[d]) begin
                        int mx = l[0];
                        int mn = l[0];
                        for (int i = 1; i < n; i++) begin
                            if (l[i] > mx) mx = l[i];
                            if (l[i] < mn) mn = l[i];
                            if (r[i] != r[0]) m_mis[d] = 1;
                        end
                        m_done[d] = 1;
                        m_lat[d]  = l[0];
                        m_skew[d] = mx - mn;
                        m_txn[d]  = sat(m_txn[d]);
                        if (mx != mn) begin
                            m_leak[d] = 1;
                            m_lc[d]   = sat(m_lc[d]);
                        end
                    end else begin
                        m_to[d]   = 1;
                        m_leak[d] = 1;
                        m_lc[d]   = sat(m_lc[d]);
                    end
                end
            end
            #1;
        end
    endtask

    initial begin
        arr4_t l, h;
        res4_t r;
        reset = 1'b1; fire = 1'b0; clear = 1'b0; valid = '0;
        for (int i = 0; i < 4; i++) res_bus[i] = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        idle(3);

        // Equal latency
        l = '{5, 5, 5, 5}; h = '{0, 0, 0, 0}; r = '{16'hAB, 16'hAB, 16'hAB, 16'hAB};
        run_txn(l, r, h, -1, -1, -1);
        idle(2);
        // Skew
        l = '{3, 7, 2, 6}; h = '{2, 0, 1, 0}; r = '{16'h5, 16'h5, 16'h5, 16'h5};
        run_txn(l, r, h, -1, -1, -1);
        idle(1);
        // Mismatch
        l = '{4, 4, 4, 4}; h = '{0, 0, 0, 0}; r = '{16'h1, 16'h2, 16'h1, 16'h1};
        run_txn(l, r, h, -1, -1, -1);
        idle(1);
        // Timeout with a held valid
        l = '{2, 0, 2, 0}; h = '{8, 0, 0, 0}; r = '{16'h7, 16'h7, 16'h7, 16'h7};
        run_txn(l, r, h, -1, -1, -1);
        idle(1);
        // Fire while busy, then clear in the cycle a skewed transaction completes
        l = '{2, 5, 4, 3}; h = '{1, 1, 1, 1}; r = '{16'h9, 16'h9, 16'h9, 16'h9};
        run_txn(l, r, h, 3, 6, -1);
        idle(1);
        // Four-lane skew, back-to-back with the next transaction
        l = '{2, 6, 3, 6}; h = '{0, 0, 0, 0}; r = '{16'h3, 16'h3, 16'h3, 16'h3};
        run_txn(l, r, h, -1, -1, -1);
        // Reset mid-WAIT, then a clean measurement
        l = '{5, 5, 5, 5}; h = '{0, 0, 0, 0};
        run_txn(l, r, h, -1, -1, 3);
        idle(2);
        l = '{4, 1, 4, 4};
        run_txn(l, r, h, -1, -1, -1);
        idle(1);

        // Random transactions, long enough for both counters to saturate
        for (int t = 0; t < 50; t++) begin
            int base, rb, e2, e4, mn_end, mx_end, pc, cc;
            base = $urandom_range(1, 8);
            rb   = $urandom;
            for (int i = 0; i < 4; i++) begin
                int sel = $urandom_range(0, 19);
                l[i] = $urandom_range(0, 1) ? base : $urandom_range(1, 8);
                if (sel == 0) l[i] = 0;
                else if (sel == 1) l[i] = TO;
                else if (sel == 2) l[i] = TO + 1;
                r[i] = $urandom_range(0, 2) != 0 ? DW'(rb) : DW'($urandom);
                h[i] = $urandom_range(0, 4);
            end
            e2 = txn_end(l, 2);
            e4 = txn_end(l, 4);
            mn_end = (e2 < e4) ? e2 : e4;
            mx_end = (e2 > e4) ? e2 : e4;
            pc = ($urandom_range(0, 5) == 0) ? $urandom_range(1, mn_end - 1) : -1;
            cc = (t < 8 && $urandom_range(0, 3) == 0) ? $urandom_range(0, mx_end - 1) : -1;
            run_txn(l, r, h, pc, cc, -1);
            idle($urandom_range(0, 3));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/se_leak_monitor.md
# se_leak_monitor

Parametrised N-lane timing-leak and result-equivalence monitor for the self-composition test harness. N identical SE instances receive the same transaction. This block:
- measures each lane's accept-to-valid latency;
- flags any cross-lane latency skew (timing leak) or result divergence;
- keeps sticky flags and saturating event counters for the formal or simulation bench.

It replaces ad-hoc combinational valid comparison with cycle-accurate, per-transaction accounting.

## Interface
- NUM_LANES, 2, number of SE lanes monitored (>= 2)
- DATA_W, 128, width of each lane's result
- CNT_W, 16, width of latency, skew and counters
- TIMEOUT, 1024, max cycles to wait for all lanes (< 2^CNT_W)

- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- io_in_fire  in  1  shared input handshake completed (valid & ready) this cycle
- io_lane_valid  in  NUM_LANES  per-lane output valid
- io_lane_result  in  NUM_LANES*DATA_W  per-lane result; lane i at bits [i*DATA_W +: DATA_W]
- io_clear  in  1  clears sticky flags and counters
- io_busy  out  1  transaction in flight (state != IDLE)
- io_done  out  1  one-cycle pulse, transaction fully completed
- io_latency  out  CNT_W  lane 0 latency of last completed transaction
- io_skew  out  CNT_W  max-min lane latency of last completed transaction
- io_leak  out  1  sticky: skew != 0 or timeout
- io_mismatch  out  1  sticky: some lane result != lane 0 result
- io_timeout  out  1  sticky: TIMEOUT reached with lanes outstanding
- io_proto_err  out  1  sticky: fire seen while busy
- io_txn_count  out  CNT_W  completed transactions, saturating
- io_leak_count  out  CNT_W  transactions that set io_leak, saturating

## Operation
- FSM IDLE -> WAIT -> DONE -> IDLE.
- IDLE:
  - io_lane_valid is ignored.
  - On io_in_fire: cnt := 1, all lane done bits cleared, go to WAIT.
- WAIT: each cycle, for each lane not yet done with valid=1:
  - set the lane's done bit;
  - capture latency := cnt;
  - capture the result.
  - Valid on an already-done lane is ignored, because SE holds valid until out_ready.
  - cnt increments each WAIT cycle.
  - When all lanes are done (including captures this cycle), go to DONE.
  - Otherwise, if cnt == TIMEOUT: set io_timeout and io_leak, increment io_leak_count, go to IDLE. No io_done pulse and no io_txn_count increment.
- DONE (one cycle):
  - Compute skew = max - min of captured latencies, and mismatch = any captured result != lane 0's.
  - At the end of this cycle, register:
    - io_done = 1;
    - io_latency and io_skew;
    - io_leak |= (skew != 0), with io_leak_count incrementing if skew != 0;
    - io_mismatch |= mismatch;
    - io_txn_count + 1.
  - Go to IDLE.
- io_in_fire in WAIT or DONE: sets io_proto_err; the fire is otherwise ignored.
- io_clear zeroes sticky flags and both counters.
  - Same-cycle set or increment wins: the flag stays 1 and the counter becomes 1.
- Counters saturate at 2^CNT_W-1.
- Upstream must drop lane valids before the next fire. A held valid seen in the first WAIT cycle counts as latency 1.

## Timing
- Reset: state IDLE, cnt 0; every output 0.
- Reset mid-transaction aborts it with no flag, counter or done update.
- Fire in cycle t: io_busy = 1 from t+1.
- A lane first valid in cycle t+k has latency k.
- Last lane valid in cycle c: DONE in c+1; io_done and updated outputs visible in c+2; IDLE in c+2.
- A fire in c+2 is accepted.
- Timeout: fire at t, flags visible at t+TIMEOUT+1, IDLE at t+TIMEOUT+1.
- io_latency and io_skew hold until the next io_done.

## Structure
- Shared package se_test_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - a saturating-increment function;
  - the default CNT_W and TIMEOUT constants.
- Sub-module se_lane_capture (one per lane): done bit, latency register (CNT_W) and result register (DATA_W), with clear-on-fire and capture-once.
- Top level holds the FSM, cycle counter, max/min/compare tree, sticky flags and counters.

## Test plan
- Equal latency, N=2, TIMEOUT=16:
  - Stimulus: fire at cycle 0; both lanes valid at cycle 5 with result 0xAB.
  - Response: io_done at cycle 7, io_latency=5, io_skew=0, no flags, io_txn_count=1.
- Skew:
  - Stimulus: lane 0 valid at cycle 3, lane 1 valid at cycle 7.
  - Response: io_done at cycle 9, io_latency=3, io_skew=4, io_leak=1, io_leak_count=1, io_mismatch=0.
- Mismatch:
  - Stimulus: both lanes valid at cycle 4, results 0x1 and 0x2.
  - Response: io_mismatch=1, io_skew=0, io_leak=0.
- Timeout and held valid:
  - Stimulus: lane 0 valid at cycle 2, held to cycle 10; lane 1 never valid.
  - Response: io_timeout=1 and io_leak=1 visible at cycle 17; no io_done; io_busy=0 at cycle 17.
- Protocol error and clear:
  - Stimulus: fire during WAIT; then io_clear in the same cycle a skewed transaction completes.
  - Response: io_proto_err=1 and the fire is ignored; after the clear, io_leak=1, io_leak_count=1, io_proto_err=0.
- N=4 and reset:
  - Stimulus: N=4 with lane latencies 2, 6, 3, 6.
  - Response: io_skew=4.
  - Stimulus: reset asserted mid-WAIT.
  - Response: all outputs 0, next transaction measured correctly.
